vshift_issue_sequencer: RTL and testbench

Sequencing stage directly upstream of `vector_shift_unit`. It accepts one decoded vector shift instruction, reads the vs2 (and, for VV, vs1) operands from the vector register file in 128-bit beats, and assembles them into the 512-bit `data2`/`data1` operands. It drives the combinational shift unit and captures `shift_result` when `shift_done` is high. It then writes the result back to vd in beats over a valid/ready handshake.

---
 rtl/vshift_issue_sequencer_pkg.sv | 34 +++
 rtl/vshift_issue_sequencer_if.sv | 52 +++++
 rtl/vshift_issue_sequencer_operand_assembler.sv | 41 ++++
 rtl/vshift_issue_sequencer.sv | 159 +++++++++++++++
 tb/tb_vshift_issue_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vshift_issue_sequencer_pkg.sv
// Shared constants and encodings for the vector shift issue sequencer and its operand path.
// The VLEN/ELEN/BEAT_W constants are used by the interface, the top and the operand assembler.
package vshift_pkg;

    localparam int VLEN   = 512;
    localparam int ELEN   = 32;
    localparam int BEAT_W = 128;
    localparam int BEATS  = VLEN / BEAT_W;

    typedef enum logic [1:0] {
        OP_VV = 2'b00,
        OP_VX = 2'b01,
        OP_VI = 2'b10
    } op_type_e;

    typedef enum logic [2:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010
    } shift_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4
    } seq_state_e;

    function automatic logic sew_ok(input logic [6:0] sew);
        return (sew == 7'd8) || (sew == 7'd16) || (sew == 7'd32);
    endfunction

endpackage

// File: rtl/vshift_issue_sequencer_if.sv
// Request, VRF read, shift-unit and writeback signals of the vector shift issue sequencer.
// The sequencer connects through the slave modport; its environment uses the master modport.
interface vshift_issue_sequencer_if;
    import vshift_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op_type;
    logic [2:0]        req_shift_op;
    logic [6:0]        req_sew;
    logic [4:0]        req_vs1;
    logic [4:0]        req_vs2;
    logic [4:0]        req_vd;
    logic [ELEN-1:0]   req_scalar;
    logic [4:0]        req_imm;
    logic              req_err;

    logic              rd_en;
    logic [4:0]        rd_addr;
    logic [1:0]        rd_beat;
    logic [BEAT_W-1:0] rd_data;

    logic [VLEN-1:0]   data1;
    logic [VLEN-1:0]   data2;
    logic [1:0]        op_type;
    logic [2:0]        shift_op;
    logic [6:0]        sew;
    logic [VLEN-1:0]   shift_result;
    logic              shift_done;

    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_addr;
    logic [1:0]        wb_beat;
    logic [BEAT_W-1:0] wb_data;
    logic              busy;

    modport slave (
        input  req_valid, req_op_type, req_shift_op, req_sew, req_vs1, req_vs2, req_vd,
               req_scalar, req_imm, rd_data, shift_result, shift_done, wb_ready,
        output req_ready, req_err, rd_en, rd_addr, rd_beat, data1, data2, op_type,
               shift_op, sew, wb_valid, wb_addr, wb_beat, wb_data, busy
    );

    modport master (
        output req_valid, req_op_type, req_shift_op, req_sew, req_vs1, req_vs2, req_vd,
               req_scalar, req_imm, rd_data, shift_result, shift_done, wb_ready,
        input  req_ready, req_err, rd_en, rd_addr, rd_beat, data1, data2, op_type,
               shift_op, sew, wb_valid, wb_addr, wb_beat, wb_data, busy
    );

endinterface

// File: rtl/vshift_issue_sequencer_operand_assembler.sv
// Builds the 512-bit data1/data2 shift operands from 128-bit VRF read beats.
// A clear seeds data1 with the scalar/immediate (zero for VV) and zeroes data2.
module vshift_operand_assembler
    import vshift_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic [ELEN-1:0]   i_d1_init,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [1:0]        i_wr_beat,
    input  logic [BEAT_W-1:0] i_wr_data,
    output logic [VLEN-1:0]   o_data1,
    output logic [VLEN-1:0]   o_data2
);

    logic [VLEN-1:0] r_data1;
    logic [VLEN-1:0] r_data2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data1 <= '0;
            r_data2 <= '0;
        end else if (i_clr) begin
            r_data1 <= {{(VLEN-ELEN){1'b0}}, i_d1_init};
            r_data2 <= '0;
        end else if (i_wr_en) begin
            // i_wr_sel picks the vs1 operand (data1); otherwise the beat belongs to vs2
            if (i_wr_sel) begin
                r_data1[i_wr_beat*BEAT_W +: BEAT_W] <= i_wr_data;
            end else begin
                r_data2[i_wr_beat*BEAT_W +: BEAT_W] <= i_wr_data;
            end
        end
    end

    assign o_data1 = r_data1;
    assign o_data2 = r_data2;

endmodule

// File: rtl/vshift_issue_sequencer.sv
// Issue sequencer in front of the vector shift unit: operand fetch, execute handoff, beat writeback.
// Reads vs2 (then vs1 for VV) beat by beat, waits for shift_done, then writes vd back in 4 beats.
//
// state   | meaning
// IDLE    | ready for a request; rejected requests pulse req_err here
// READ    | one VRF read per cycle: vs2 beats 0..3, then vs1 beats 0..3 for VV
// DRAIN   | final read beat lands in the operand registers
// EXEC    | operands held stable, waiting for shift_done
// WRITE   | result beats 0..3 offered on the writeback handshake
module vshift_issue_sequencer
    import vshift_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    vshift_issue_sequencer_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_READ  = S_READ;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;
    localparam logic [2:0] ST_EXEC  = S_EXEC;
    localparam logic [2:0] ST_WRITE = S_WRITE;

    logic [2:0]      r_state;
    logic            r_req_err;
    logic [1:0]      r_op_type;
    logic [2:0]      r_shift_op;
    logic [6:0]      r_sew;
    logic [4:0]      r_vs1;
    logic [4:0]      r_vs2;
    logic [4:0]      r_vd;
    logic [2:0]      r_rd_cnt;
    logic            r_cap_en;
    logic [2:0]      r_cap_idx;
    logic [VLEN-1:0] r_result;
    logic [1:0]      r_wb_beat;

    logic            w_accept;
    logic            w_req_ok;
    logic            w_rd_en;
    logic            w_rd_last;
    logic            w_wb_valid;
    logic [ELEN-1:0] w_d1_init;

    assign w_accept   = (r_state == ST_IDLE) && !r_req_err && bus.req_valid;
    assign w_req_ok   = sew_ok(bus.req_sew) && (bus.req_op_type != 2'b11);
    assign w_rd_en    = (r_state == ST_READ);
    assign w_rd_last  = (r_rd_cnt == ((r_op_type == OP_VV) ? 3'd7 : 3'd3));
    assign w_wb_valid = (r_state == ST_WRITE);

    // VX/VI place the raw scalar/immediate in data1; the shift unit does the broadcast
    always_comb begin
        w_d1_init = '0;
        if (bus.req_op_type == OP_VX) begin
            w_d1_init = bus.req_scalar;
        end else if (bus.req_op_type == OP_VI) begin
            w_d1_init = {{(ELEN-5){1'b0}}, bus.req_imm};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req_err  <= 1'b0;
            r_op_type  <= '0;
            r_shift_op <= '0;
            r_sew      <= '0;
            r_vs1      <= '0;
            r_vs2      <= '0;
            r_vd       <= '0;
            r_rd_cnt   <= '0;
            r_cap_en   <= 1'b0;
            r_cap_idx  <= '0;
            r_result   <= '0;
            r_wb_beat  <= '0;
        end else begin
            r_req_err <= 1'b0;
            r_cap_en  <= w_rd_en;
            r_cap_idx <= r_rd_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_type  <= bus.req_op_type;
                        r_shift_op <= bus.req_shift_op;
                        r_sew      <= bus.req_sew;
                        r_vs1      <= bus.req_vs1;
                        r_vs2      <= bus.req_vs2;
                        r_vd       <= bus.req_vd;
                        if (w_req_ok) begin
                            r_rd_cnt <= '0;
                            r_state  <= ST_READ;
                        end else begin
                            r_req_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_rd_cnt <= r_rd_cnt + 3'd1;
                    if (w_rd_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (bus.shift_done) begin
                        r_result  <= bus.shift_result;
                        r_wb_beat <= '0;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.wb_ready) begin
                        r_wb_beat <= r_wb_beat + 2'd1;
                        if (r_wb_beat == 2'(BEATS - 1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read beat index bit 2 selects vs1; capture happens one cycle later with the returning data
    vshift_operand_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_accept && w_req_ok),
        .i_d1_init (w_d1_init),
        .i_wr_en   (r_cap_en),
        .i_wr_sel  (r_cap_idx[2]),
        .i_wr_beat (r_cap_idx[1:0]),
        .i_wr_data (bus.rd_data),
        .o_data1   (bus.data1),
        .o_data2   (bus.data2)
    );

    assign bus.req_ready = (r_state == ST_IDLE) && !r_req_err;
    assign bus.req_err   = r_req_err;
    assign bus.busy      = (r_state != ST_IDLE);

    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = w_rd_en ? (r_rd_cnt[2] ? r_vs1 : r_vs2) : 5'd0;
    assign bus.rd_beat   = w_rd_en ? r_rd_cnt[1:0] : 2'd0;

    assign bus.op_type   = r_op_type;
    assign bus.shift_op  = r_shift_op;
    assign bus.sew       = r_sew;

    assign bus.wb_valid  = w_wb_valid;
    assign bus.wb_addr   = w_wb_valid ? r_vd : 5'd0;
    assign bus.wb_beat   = r_wb_beat;
    assign bus.wb_data   = w_wb_valid ? r_result[r_wb_beat*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_vshift_issue_sequencer.sv
// Directed bench for vshift_issue_sequencer with a VRF model, a shift-unit stub and a per-cycle
// transaction-level reference model; hand-computed literals pin the key scenarios.
module tb_vshift_issue_sequencer;
    import vshift_pkg::*;

    logic clk;
    logic reset;

    vshift_issue_sequencer_if u_if ();

    vshift_issue_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [511:0] vrf [32];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Element-wise shift of d2 by amounts in d1 (per element) or by d1's low bits (broadcast)
    function automatic logic [511:0] shift_vec(input logic [511:0] d2, input logic [511:0] d1,
                                               input logic bcast, input logic [2:0] sop,
                                               input logic [6:0] sew_in);
        logic [511:0] r;
        int w;
        int ne;
        logic [31:0] mask;
        r = '0;
        w = (sew_in == 7'd16) ? 16 : (sew_in == 7'd32) ? 32 : 8;
        ne = 512 / w;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        for (int i = 0; i < ne; i++) begin
            logic [31:0] a;
            logic [31:0] s;
            logic [31:0] y;
            int amt;
            a = 32'(d2 >> (i * w)) & mask;
            s = bcast ? d1[31:0] : 32'(d1 >> (i * w));
            amt = int'(s & 32'(w - 1));
            if (sop == 3'b000) begin
                y = a << amt;
            end else if (sop == 3'b001) begin
                y = a >> amt;
            end else begin
                if (a[w-1]) a = a | ~mask;
                y = $signed(a) >>> amt;
            end
            r = r | (512'(y & mask) << (i * w));
        end
        return r;
    endfunction

    // Shift-unit stub: combinational result, always done
    always_comb begin
        u_if.shift_result = shift_vec(u_if.data2, u_if.data1, u_if.op_type != 2'b00,
                                      u_if.shift_op, u_if.sew);
    end

    // VRF read port: data one cycle after rd_en, garbage otherwise
    always @(posedge clk) begin
        if (u_if.rd_en) u_if.rd_data <= vrf[u_if.rd_addr][u_if.rd_beat*128 +: 128];
        else            u_if.rd_data <= {4{32'hA5A5_5A5A}};
    end

    // Reference model state (0 idle, 1 reject pulse cycle, 2 running)
    int           m_mode = 0;
    int           acc_t = 0;
    int           m_n;
    int           m_widx;
    logic         m_vv;
    logic [4:0]   m_vs1, m_vs2, m_vd;
    logic [1:0]   m_op;
    logic [2:0]   m_sop;
    logic [6:0]   m_sew;
    logic [511:0] m_d1, m_d2, m_res;

    // Observations of the current operation, compared against literals by the stimulus
    int           done_t, err_t, rd_n, vs1_n, wb_n;
    logic [127:0] cap [4];
    int           ord [$];
    logic [511:0] obs_d1;

    always @(negedge clk) begin
        logic e_ready, e_err, e_busy, e_rd, e_wb;
        if (reset) m_mode = 0;
        acc_t++;
        e_ready = (m_mode == 0);
        e_err   = (m_mode == 1);
        e_busy  = (m_mode == 2);
        e_rd    = (m_mode == 2) && acc_t >= 1 && acc_t <= m_n;
        e_wb    = (m_mode == 2) && acc_t >= m_n + 3;
        chk("req_ready", 512'(u_if.req_ready), 512'(e_ready));
        chk("req_err",   512'(u_if.req_err),   512'(e_err));
        chk("busy",      512'(u_if.busy),      512'(e_busy));
        chk("rd_en",     512'(u_if.rd_en),     512'(e_rd));
        chk("wb_valid",  512'(u_if.wb_valid),  512'(e_wb));
        if (e_rd) begin
            chk("rd_addr", 512'(u_if.rd_addr), 512'((acc_t <= 4) ? m_vs2 : m_vs1));
            chk("rd_beat", 512'(u_if.rd_beat), 512'((acc_t - 1) % 4));
        end
        if (e_wb) begin
            chk("wb_addr", 512'(u_if.wb_addr), 512'(m_vd));
            chk("wb_beat", 512'(u_if.wb_beat), 512'(m_widx));
            chk("wb_data", 512'(u_if.wb_data), 512'(m_res[m_widx*128 +: 128]));
        end
        if (m_mode == 2 && acc_t == m_n + 2) begin
            chk("data1",    u_if.data1, m_d1);
            chk("data2",    u_if.data2, m_d2);
            chk("op_type",  512'(u_if.op_type),  512'(m_op));
            chk("shift_op", 512'(u_if.shift_op), 512'(m_sop));
            chk("sew",      512'(u_if.sew),      512'(m_sew));
            obs_d1 = u_if.data1;
        end

        if (u_if.req_ready && done_t < 0) done_t = acc_t;
        if (u_if.req_err && err_t < 0) err_t = acc_t;
        if (u_if.rd_en) begin
            rd_n++;
            if (u_if.rd_addr == m_vs1) vs1_n++;
        end
        if (u_if.wb_valid && u_if.wb_ready) begin
            cap[u_if.wb_beat] = u_if.wb_data;
            ord.push_back(int'(u_if.wb_beat));
            wb_n++;
        end

        if (!reset) begin
            case (m_mode)
                0: if (u_if.req_valid) begin
                    acc_t = 0; done_t = -1; err_t = -1; rd_n = 0; vs1_n = 0; wb_n = 0;
                    ord.delete();
                    for (int b = 0; b < 4; b++) cap[b] = '0;
                    m_op = u_if.req_op_type; m_sop = u_if.req_shift_op; m_sew = u_if.req_sew;
                    m_vs1 = u_if.req_vs1; m_vs2 = u_if.req_vs2; m_vd = u_if.req_vd;
                    m_vv = (m_op == 2'b00); m_n = m_vv ? 8 : 4; m_widx = 0;
                    if (m_op == 2'b11 || !(m_sew == 7'd8 || m_sew == 7'd16 || m_sew == 7'd32)) begin
                        m_mode = 1;
                    end else begin
                        m_mode = 2;
                        m_d2 = vrf[m_vs2];
                        m_d1 = m_vv ? vrf[m_vs1] :
                               (m_op == 2'b01) ? 512'(u_if.req_scalar) : 512'(u_if.req_imm);
                        m_res = shift_vec(m_d2, m_d1, !m_vv, m_sop, m_sew);
                    end
                end
                1: m_mode = 0;
                default: if (acc_t >= m_n + 3 && u_if.wb_ready) begin
                    m_widx++;
                    if (m_widx == 4) m_mode = 0;
                end
            endcase
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] sop, input logic [6:0] sw,
                        input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                        input logic [31:0] scal, input logic [4:0] imm);
        u_if.req_op_type = op; u_if.req_shift_op = sop; u_if.req_sew = sw;
        u_if.req_vs1 = vs1; u_if.req_vs2 = vs2; u_if.req_vd = vd;
        u_if.req_scalar = scal; u_if.req_imm = imm;
        u_if.req_valid = 1'b1;
        @(posedge clk); #1;
        u_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (m_mode != 0 && k < 200);
        if (m_mode != 0) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles want idle", nm, k);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_widx(input int idx, input string nm);
        int k;
        k = 0;
        while (!(m_mode == 2 && m_widx == idx) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got no beat %0d want beat %0d", nm, idx, idx);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) vrf[r] = '0;
        vrf[2][15:0] = {8'd20, 8'd10};
        vrf[3][15:0] = {8'd2, 8'd1};
        vrf[5][31:0] = {16'd128, 16'd64};
        vrf[7] = {16{32'h0000_0F0F}};
        for (int b = 0; b < 16; b++) begin
            vrf[8][b*32 +: 32] = 32'h9E37_79B9 * 32'(b + 1);
            vrf[9][b*32 +: 32] = 32'(b * 3 + 1);
        end

        reset = 1'b1;
        u_if.wb_ready = 1'b1;
        u_if.shift_done = 1'b1;
        // A request presented during reset must be ignored
        u_if.req_op_type = 2'b00; u_if.req_shift_op = 3'b000; u_if.req_sew = 7'd8;
        u_if.req_vs1 = 5'd3; u_if.req_vs2 = 5'd2; u_if.req_vd = 5'd4;
        u_if.req_scalar = '0; u_if.req_imm = '0;
        u_if.req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data1",   u_if.data1, '0);
        chk("rst_data2",   u_if.data2, '0);
        chk("rst_ctrl",    512'({u_if.op_type, u_if.shift_op, u_if.sew}), '0);
        chk("rst_outs",    512'({u_if.wb_addr, u_if.wb_beat, u_if.rd_addr, u_if.rd_beat}), '0);
        chk("rst_wb_data", 512'(u_if.wb_data), '0);
        reset = 1'b0;
        u_if.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // VV SLL, SEW 8
        send(2'b00, 3'b000, 7'd8, 5'd3, 5'd2, 5'd4, 32'd0, 5'd0);
        wait_idle("vv_sll");
        chk("vv_beat0",   512'(cap[0]), 512'(128'h5014));
        chk("vv_beat123", 512'({cap[3], cap[2], cap[1]}), '0);
        chk("vv_rd_cnt",  512'(rd_n), 512'(8));
        chk("vv_done_t",  512'(done_t), 512'(15));

        // VX SRL, scalar 2
        send(2'b01, 3'b001, 7'd8, 5'd0, 5'd2, 5'd6, 32'd2, 5'd0);
        wait_idle("vx_srl");
        chk("vx_data1",  obs_d1, 512'h2);
        chk("vx_beat0",  512'(cap[0]), 512'(128'h0502));
        chk("vx_rd_cnt", 512'(rd_n), 512'(4));
        chk("vx_done_t", 512'(done_t), 512'(11));

        // VI SRA, SEW 16, imm 3; vs1 field points at a non-zero register that must not be read
        send(2'b10, 3'b010, 7'd16, 5'd7, 5'd5, 5'd6, 32'd0, 5'd3);
        wait_idle("vi_sra");
        chk("vi_beat0",  512'(cap[0]), 512'(128'h0010_0008));
        chk("vi_vs1_rd", 512'(vs1_n), 512'(0));
        chk("vi_done_t", 512'(done_t), 512'(11));

        // Backpressure: 3 stall cycles while beat 1 is offered
        send(2'b00, 3'b000, 7'd32, 5'd9, 5'd8, 5'd10, 32'd0, 5'd0);
        wait_widx(1, "bp");
        u_if.wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        u_if.wb_ready = 1'b1;
        wait_idle("bp");
        chk("bp_order",  512'({ord.size() == 4 ? 1'b1 : 1'b0}), 512'(1));
        if (ord.size() == 4) begin
            chk("bp_order_beats", 512'({ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]}),
                512'(8'b00_01_10_11));
        end
        chk("bp_done_t", 512'(done_t), 512'(18));

        // Rejections: bad SEW, then reserved op type
        send(2'b00, 3'b000, 7'd12, 5'd3, 5'd2, 5'd4, 32'd0, 5'd0);
        wait_idle("rej_sew");
        chk("rej_sew_err_t",  512'(err_t), 512'(1));
        chk("rej_sew_done_t", 512'(done_t), 512'(2));
        chk("rej_sew_quiet",  512'(rd_n + wb_n), '0);
        send(2'b11, 3'b000, 7'd8, 5'd3, 5'd2, 5'd4, 32'd0, 5'd0);
        wait_idle("rej_op");
        chk("rej_op_err_t",  512'(err_t), 512'(1));
        chk("rej_op_done_t", 512'(done_t), 512'(2));
        chk("rej_op_quiet",  512'(rd_n + wb_n), '0);

        // Reset after beat 1 accepted, vd overlapping vs2
        send(2'b00, 3'b010, 7'd16, 5'd9, 5'd8, 5'd8, 32'd0, 5'd0);
        wait_widx(2, "rst_mid");
        reset = 1'b1;
        #1;
        chk("rstmid_wb_valid", 512'(u_if.wb_valid), '0);
        chk("rstmid_busy",     512'(u_if.busy), '0);
        chk("rstmid_ready",    512'(u_if.req_ready), 512'(1));
        chk("rstmid_data",     u_if.data1 | u_if.data2, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(2'b00, 3'b000, 7'd8, 5'd3, 5'd2, 5'd4, 32'd0, 5'd0);
        wait_idle("post_rst");
        chk("post_rst_beat0",  512'(cap[0]), 512'(128'h5014));
        chk("post_rst_done_t", 512'(done_t), 512'(15));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
